// File: rtl/gf2m_pkg.sv
// gf2m_pkg: field constants and FSM encoding for the GF(2^163) inverter
package gf2m_pkg;
  localparam int M = 163;
  localparam logic [M-1:0] F_LOW = 163'hC9;
  localparam logic [M:0] F = {1'b1, F_LOW};
  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;
endpackage

// File: rtl/gf2m_halve.sv
// gf2m_halve: combinational g / x mod f
module gf2m_halve
  import gf2m_pkg::*;
(
  input  logic [M-1:0] g,
  output logic [M-1:0] h
);
  // odd g: add f first so the division is exact; f's x^M term becomes the new msb
  always_comb h = {g[0], g[M-1:1] ^ (g[0] ? F_LOW[M-1:1] : {(M-1){1'b0}})};
endmodule

// File: rtl/gf2m_inverter.sv
// gf2m_inverter: GF(2^163) inverse by binary extended Euclid, one step per clock.
// Optional macro GF_INV_CYCLE_CNT_EN adds a 10-bit ITER cycle count output.
module gf2m_inverter
  import gf2m_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] A,
  output logic [M-1:0] Z,
  output logic         done,
  output logic         busy,
  output logic         err
`ifdef GF_INV_CYCLE_CNT_EN
  ,
  output logic [9:0]   cycles
`endif
);
  state_t state, nxt;
  logic [M:0] u, v;
  logic [M-1:0] g1, g2, h1, h2;
  logic u_one, v_one, a_zero;
  gf2m_halve u_h1 (.g(g1), .h(h1));
  gf2m_halve u_h2 (.g(g2), .h(h2));
  always_comb begin
    u_one = u == (M+1)'(1);
    v_one = v == (M+1)'(1);
    a_zero = A == '0;
    nxt = state == IDLE ? (start ? LOAD : IDLE) :
          state == LOAD ? (a_zero ? DONE : ITER) :
          state == ITER ? ((u_one || v_one) ? DONE : ITER) : IDLE;
    done = state == DONE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // Z/err are written on the edge entering DONE so they are valid while done is high
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      u <= '0;
      v <= '0;
      g1 <= '0;
      g2 <= '0;
      Z <= '0;
      err <= 1'b0;
    end else if (state == LOAD) begin
      u <= {1'b0, A};
      v <= F;
      g1 <= M'(1);
      g2 <= '0;
      if (a_zero) begin
        Z <= '0;
        err <= 1'b1;
      end
    end else if (state == ITER) begin
      if (u_one) begin
        Z <= g1;
        err <= 1'b0;
      end else if (v_one) begin
        Z <= g2;
        err <= 1'b0;
      end else if (!u[0]) begin
        u <= u >> 1;
        g1 <= h1;
      end else if (!v[0]) begin
        v <= v >> 1;
        g2 <= h2;
      end else if (u > v) begin
        u <= u ^ v;
        g1 <= g1 ^ g2;
      end else begin
        v <= v ^ u;
        g2 <= g2 ^ g1;
      end
    end
`ifdef GF_INV_CYCLE_CNT_EN
  logic [9:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      cycles <= '0;
    end else if (state == LOAD) begin
      cnt <= '0;
      if (a_zero) cycles <= '0;
    end else if (state == ITER) begin
      cnt <= cnt + 10'd1;
      if (u_one || v_one) cycles <= cnt + 10'd1;
    end
`endif
endmodule
